// File: rtl/pcsa_pkg.sv
// Shared configuration, elaboration helpers and stage record type for the
// pipelined carry-skip adder.
package pcsa_pkg;

    localparam int DEF_ADDER_WIDTH  = 32;
    localparam int DEF_BLOCK_WIDTH  = 4;
    localparam int DEF_NUM_STAGES   = 2;
    localparam int NUM_BLOCKS       = DEF_ADDER_WIDTH / DEF_BLOCK_WIDTH;
    localparam int BLOCKS_PER_STAGE = NUM_BLOCKS / DEF_NUM_STAGES;

    function automatic int calc_num_blocks(input int aw, input int bw);
        return aw / bw;
    endfunction

    function automatic int calc_blocks_per_stage(input int aw, input int bw, input int ns);
        return (aw / bw) / ns;
    endfunction

    // A legal configuration tiles the operand exactly into blocks and the blocks evenly into stages.
    function automatic bit cfg_ok(input int aw, input int bw, input int ns);
        return (bw > 0) && (ns > 0) && (aw >= bw) && ((aw % bw) == 0) &&
               (((aw / bw) % ns) == 0);
    endfunction

    typedef struct packed {
        logic                       valid;
        logic [DEF_ADDER_WIDTH-1:0] sum;
        logic [DEF_ADDER_WIDTH-1:0] rem_a;
        logic [DEF_ADDER_WIDTH-1:0] rem_b;
        logic                       carry;
        logic                       msb_carry_in;
    } stage_rec_t;

endpackage

// File: rtl/carry_skip_block.sv
// One carry-skip slice: ripple adder whose carry-out bypasses the ripple
// chain when every bit of the slice propagates.
module carry_skip_block
    import pcsa_pkg::*;
#(
    parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH
) (
    input  logic [BLOCK_WIDTH-1:0] a,
    input  logic [BLOCK_WIDTH-1:0] b,
    input  logic                   cin,
    output logic [BLOCK_WIDTH-1:0] sum,
    output logic                   cout,
    output logic                   msb_cin
);

    logic [BLOCK_WIDTH:0] ripple_c_s;
    logic                 prop_s;

    // Ripple sum and carry chain across the slice.
    always_comb begin
        ripple_c_s    = '0;
        sum           = '0;
        ripple_c_s[0] = cin;
        for (int i = 0; i < BLOCK_WIDTH; i++) begin
            sum[i]          = a[i] ^ b[i] ^ ripple_c_s[i];
            ripple_c_s[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & ripple_c_s[i]);
        end
    end

    assign prop_s  = &(a ^ b);
    assign cout    = prop_s ? cin : ripple_c_s[BLOCK_WIDTH];
    assign msb_cin = ripple_c_s[BLOCK_WIDTH-1];

endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip adder/subtractor: blocks are spread evenly over
// NUM_STAGES register stages with a valid/ready handshake on both ends.
module pipelined_carry_skip_adder
    import pcsa_pkg::*;
#(
    parameter int ADDER_WIDTH = DEF_ADDER_WIDTH,
    parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
    parameter int NUM_STAGES  = DEF_NUM_STAGES
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iValid,
    output logic                   oReady,
    input  logic [ADDER_WIDTH-1:0] iA,
    input  logic [ADDER_WIDTH-1:0] iB,
    input  logic                   iCarry,
    input  logic                   iSub,
    output logic                   oValid,
    input  logic                   iReady,
    output logic [ADDER_WIDTH-1:0] oSum,
    output logic                   oCarry,
    output logic                   oOverflow
);

    localparam int NB = calc_num_blocks(ADDER_WIDTH, BLOCK_WIDTH);
    localparam int K  = calc_blocks_per_stage(ADDER_WIDTH, BLOCK_WIDTH, NUM_STAGES);
    localparam int BW = BLOCK_WIDTH;

    if (!cfg_ok(ADDER_WIDTH, BLOCK_WIDTH, NUM_STAGES)) begin : g_cfg_check
        $error("pipelined_carry_skip_adder: ADDER_WIDTH/BLOCK_WIDTH/NUM_STAGES do not tile evenly");
    end

    logic [NUM_STAGES-1:0]  vld_r;
    logic [NUM_STAGES-1:0]  carry_r;
    logic [ADDER_WIDTH-1:0] sum_r     [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] a_r       [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] b_r       [NUM_STAGES];
    logic                   ovf_r;

    logic [NUM_STAGES-1:0]  adv_s;
    logic [NUM_STAGES-1:0]  in_vld_s;
    logic                   in_c_s    [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] in_a_s    [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] in_b_s    [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] in_sum_s  [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] nxt_sum_s [NUM_STAGES];
    logic                   nxt_c_s   [NUM_STAGES];
    logic                   blk_msb_s [NB];
    logic                   ovf_nxt_s;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        // Stage 0 folds subtraction into the operands: A + ~B + 1.
        if (s == 0) begin : g_first
            assign in_vld_s[s] = iValid;
            assign in_a_s[s]   = iA;
            assign in_b_s[s]   = iSub ? ~iB : iB;
            assign in_c_s[s]   = iSub ? 1'b1 : iCarry;
            assign in_sum_s[s] = '0;
        end else begin : g_next
            assign in_vld_s[s] = vld_r[s-1];
            assign in_a_s[s]   = a_r[s-1];
            assign in_b_s[s]   = b_r[s-1];
            assign in_c_s[s]   = carry_r[s-1];
            assign in_sum_s[s] = sum_r[s-1];
        end

        for (genvar k = 0; k < K; k++) begin : g_blk
            localparam int J = s * K + k;
            logic          cin_s;
            logic          cout_s;
            logic [BW-1:0] bsum_s;

            if (k == 0) begin : g_cin_first
                assign cin_s = in_c_s[s];
            end else begin : g_cin_chain
                assign cin_s = g_blk[k-1].cout_s;
            end

            carry_skip_block #(
                .BLOCK_WIDTH (BLOCK_WIDTH)
            ) u_blk (
                .a       (in_a_s[s][J*BW +: BW]),
                .b       (in_b_s[s][J*BW +: BW]),
                .cin     (cin_s),
                .sum     (bsum_s),
                .cout    (cout_s),
                .msb_cin (blk_msb_s[J])
            );
        end

        // Slices owned by this stage take the fresh block sums; the rest pass through.
        for (genvar j = 0; j < NB; j++) begin : g_slice
            if ((j / K) == s) begin : g_own
                assign nxt_sum_s[s][j*BW +: BW] = g_blk[j - s*K].bsum_s;
            end else begin : g_pass
                assign nxt_sum_s[s][j*BW +: BW] = in_sum_s[s][j*BW +: BW];
            end
        end

        assign nxt_c_s[s] = g_blk[K-1].cout_s;
    end

    assign ovf_nxt_s = blk_msb_s[NB-1] ^ nxt_c_s[NUM_STAGES-1];

    // Advance chain from the output back to the input; empty stages always advance.
    always_comb begin
        logic run_v;
        adv_s = '0;
        run_v = iReady;
        for (int s = NUM_STAGES - 1; s >= 0; s--) begin
            run_v    = !vld_r[s] || run_v;
            adv_s[s] = run_v;
        end
    end

    assign oReady = adv_s[0] && !iRst;

    // Stage registers: shift on advance, capture data only for valid entries.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            vld_r   <= '0;
            carry_r <= '0;
            ovf_r   <= 1'b0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                sum_r[s] <= '0;
                a_r[s]   <= '0;
                b_r[s]   <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (adv_s[s]) begin
                    vld_r[s] <= in_vld_s[s];
                    if (in_vld_s[s]) begin
                        sum_r[s]   <= nxt_sum_s[s];
                        a_r[s]     <= in_a_s[s];
                        b_r[s]     <= in_b_s[s];
                        carry_r[s] <= nxt_c_s[s];
                    end
                end
            end
            if (adv_s[NUM_STAGES-1] && in_vld_s[NUM_STAGES-1]) begin
                ovf_r <= ovf_nxt_s;
            end
        end
    end

    assign oValid    = vld_r[NUM_STAGES-1];
    assign oSum      = sum_r[NUM_STAGES-1];
    assign oCarry    = carry_r[NUM_STAGES-1];
    assign oOverflow = ovf_r;

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Directed/table-driven bench: default 32/4/2 instance plus a 16/2/4 instance
// for reset-in-flight and deeper latency.
module tb_pipelined_carry_skip_adder;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        co;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        co;
        logic        ovf;
    } exp_t;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, vin_a, rdy_out_a, cin_a, sub_a, vout_a, rdy_in_a, co_a, ovf_a;
    logic [31:0] a_a, b_a, sum_a;
    logic        rst_b, vin_b, rdy_out_b, cin_b, sub_b, vout_b, rdy_in_b, co_b, ovf_b;
    logic [15:0] a_b, b_b, sum_b;

    pipelined_carry_skip_adder dut_a (
        .iClk(clk), .iRst(rst_a), .iValid(vin_a), .oReady(rdy_out_a),
        .iA(a_a), .iB(b_a), .iCarry(cin_a), .iSub(sub_a),
        .oValid(vout_a), .iReady(rdy_in_a), .oSum(sum_a), .oCarry(co_a), .oOverflow(ovf_a)
    );

    pipelined_carry_skip_adder #(.ADDER_WIDTH(16), .BLOCK_WIDTH(2), .NUM_STAGES(4)) dut_b (
        .iClk(clk), .iRst(rst_b), .iValid(vin_b), .oReady(rdy_out_b),
        .iA(a_b), .iB(b_b), .iCarry(cin_b), .iSub(sub_b),
        .oValid(vout_b), .iReady(rdy_in_b), .oSum(sum_b), .oCarry(co_b), .oOverflow(ovf_b)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    int          occ;
    int          acc_cnt;
    bit          stall_prev;
    logic [31:0] held_sum;
    logic        held_co, held_ovf;
    vec_t        tab_a[10];
    vec_t        tab_b[3];
    vec_t        v_ovf_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic sub);
        exp_t        e;
        logic [31:0] bb;
        logic [32:0] r;
        bb    = sub ? ~b : b;
        r     = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
        e.sum = r[31:0];
        e.co  = r[32];
        e.ovf = (a[31] == bb[31]) && (r[31] != a[31]);
        return e;
    endfunction

    task automatic drive(input bit use_b, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic cin, input logic sub);
        if (use_b) begin
            vin_b = v; a_b = a[15:0]; b_b = b[15:0]; cin_b = cin; sub_b = sub;
        end else begin
            vin_a = v; a_a = a; b_a = b; cin_a = cin; sub_a = sub;
        end
    endtask

    // One isolated operation with exact latency check.
    task automatic single(input bit use_b, input vec_t v);
        int lat;
        lat = use_b ? 4 : 2;
        @(negedge clk);
        drive(use_b, 1'b1, v.a, v.b, v.cin, v.sub);
        #1 chk1("accept_ready", use_b ? rdy_out_b : rdy_out_a, 1'b1);
        @(negedge clk);
        drive(use_b, 1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom));
        for (int i = 1; i < lat; i++) begin
            chk1("latency_early_valid", use_b ? vout_b : vout_a, 1'b0);
            @(negedge clk);
        end
        chk1("result_valid", use_b ? vout_b : vout_a, 1'b1);
        chk("result_sum", use_b ? {16'd0, sum_b} : sum_a, v.sum);
        chk1("result_carry", use_b ? co_b : co_a, v.co);
        chk1("result_ovf", use_b ? ovf_b : ovf_a, v.ovf);
    endtask

    // One streaming cycle on instance A against the occupancy/scoreboard model.
    task automatic cycle_a(input bit rdy, input bit offer, input logic [31:0] a,
                           input logic [31:0] b, input logic cin, input logic sub);
        exp_t e;
        @(negedge clk);
        rdy_in_a = rdy;
        drive(1'b0, offer, a, b, cin, sub);
        #1;
        chk1("ready_model", rdy_out_a, rdy || (occ < 2));
        if (stall_prev) begin
            chk1("stall_valid", vout_a, 1'b1);
            chk("stall_sum", sum_a, held_sum);
            chk1("stall_carry", co_a, held_co);
            chk1("stall_ovf", ovf_a, held_ovf);
        end
        if (vout_a && rdy) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got sum 0x%0h, expected no result", sum_a);
            end else begin
                e = q.pop_front();
                chk("stream_sum", sum_a, e.sum);
                chk1("stream_carry", co_a, e.co);
                chk1("stream_ovf", ovf_a, e.ovf);
                occ--;
            end
        end
        if (offer && rdy_out_a) begin
            q.push_back(model32(a, b, cin, sub));
            occ++;
            acc_cnt++;
        end
        stall_prev = vout_a && !rdy;
        held_sum   = sum_a;
        held_co    = co_a;
        held_ovf   = ovf_a;
    endtask

    initial begin
        tab_a[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tab_a[1] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tab_a[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tab_a[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
        tab_a[4] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tab_a[5] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tab_a[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
        tab_a[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tab_a[8] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
        tab_a[9] = '{32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tab_b[0] = '{32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tab_b[1] = '{32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_7FFF, 1'b1, 1'b1};
        tab_b[2] = '{32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0, 32'h0000_68AC, 1'b0, 1'b0};
        v_ovf_b  = '{32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_8000, 1'b0, 1'b1};

        // Reset held for three edges with an operation offered.
        rst_a = 1'b1; rst_b = 1'b1; rdy_in_a = 1'b1; rdy_in_b = 1'b1;
        drive(1'b0, 1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("rst_ready_a", rdy_out_a, 1'b0);
            chk1("rst_valid_a", vout_a, 1'b0);
            chk("rst_sum_a", sum_a, 32'd0);
            chk1("rst_carry_a", co_a, 1'b0);
            chk1("rst_ovf_a", ovf_a, 1'b0);
            chk1("rst_ready_b", rdy_out_b, 1'b0);
            chk1("rst_valid_b", vout_b, 1'b0);
        end
        rst_a = 1'b0; rst_b = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        chk1("ready_after_rst_a", rdy_out_a, 1'b1);
        chk1("ready_after_rst_b", rdy_out_b, 1'b1);

        for (int i = 0; i < 10; i++) single(1'b0, tab_a[i]);
        for (int i = 0; i < 3; i++) single(1'b1, tab_b[i]);

        // Back-to-back: eight consecutive ops, eight consecutive results.
        occ = 0; acc_cnt = 0; stall_prev = 1'b0; q.delete();
        for (int i = 0; i < 10; i++) begin
            cycle_a(1'b1, i < 8, $urandom, $urandom, 1'($urandom), 1'($urandom));
            chk1("b2b_valid", vout_a, (i >= 2) && (i < 10));
        end
        chk("b2b_accepted", 32'(acc_cnt), 32'd4 + 32'd4);

        // Backpressure: downstream stalls for five cycles while four ops are offered.
        occ = 0; acc_cnt = 0; stall_prev = 1'b0; q.delete();
        for (int c = 0; c < 30 && (acc_cnt < 4 || occ > 0); c++) begin
            cycle_a(c >= 5, acc_cnt < 4, $urandom, $urandom, 1'($urandom), 1'($urandom));
        end
        chk("bp_accepted", 32'(acc_cnt), 32'd4);
        chk("bp_drained", 32'(occ), 32'd0);
        chk("bp_queue_empty", 32'(q.size()), 32'd0);

        // Reset while three ops are in flight in the 4-stage instance.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
            #1 chk1("b_fill_ready", rdy_out_b, 1'b1);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst_b = 1'b1;
        #1 chk1("b_midrst_ready", rdy_out_b, 1'b0);
        @(negedge clk);
        rst_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk1("b_flushed_valid", vout_b, 1'b0);
            @(negedge clk);
        end
        single(1'b1, v_ovf_b);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_carry_skip_adder.md
Name: pipelined_carry_skip_adder

Overview:
- Parametrised, pipelined carry-skip adder/subtractor with a valid/ready stream interface on both sides. It is the next generation of the team's combinational carry-bypass adder.
- Operands are split into fixed-width carry-skip blocks. The blocks are spread evenly across NUM_STAGES register stages, and the carry ripples stage to stage.
- Sits in datapaths that need a wide add at high clock rate with backpressure, e.g. accumulator and ALU pipelines.

Parameters:
- ADDER_WIDTH, 32, operand/sum width; must be a multiple of BLOCK_WIDTH.
- BLOCK_WIDTH, 4, bits per carry-skip block.
- NUM_STAGES, 2, pipeline register stages (= latency); (ADDER_WIDTH/BLOCK_WIDTH) must be a multiple of NUM_STAGES.

Ports:
- iClk  input  1  clock; all state updates on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iValid  input  1  upstream offers an operation this cycle.
- oReady  output  1  block accepts the offered operation this cycle.
- iA  input  ADDER_WIDTH  operand A.
- iB  input  ADDER_WIDTH  operand B.
- iCarry  input  1  carry-in; used only when iSub=0.
- iSub  input  1  1: compute A + ~B + 1 (A-B); 0: compute A + B + iCarry.
- oValid  output  1  result available.
- iReady  input  1  downstream accepts the result.
- oSum  output  ADDER_WIDTH  result.
- oCarry  output  1  raw carry-out of the MSB block; not inverted to borrow for subtraction.
- oOverflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- One clock (iClk); reset iRst is synchronous and active-high.
- Reset (iRst=1 at a rising edge):
  - all stage valid bits and data registers clear;
  - oValid=0, oSum=0, oCarry=0, oOverflow=0;
  - oReady is forced 0 while iRst=1;
  - reset mid-operation discards all in-flight results; nothing is emitted afterwards.
- Block function, per BLOCK_WIDTH slice:
  - ripple sum of a, b and block carry-in;
  - block propagate P = AND of (a XOR b) across the slice;
  - block carry-out = P ? block carry-in : ripple carry-out;
  - sums must equal exact binary addition for all inputs.
- Stage s (0..NUM_STAGES-1) computes blocks [s*K, (s+1)*K), where K = (ADDER_WIDTH/BLOCK_WIDTH)/NUM_STAGES.
- Each stage registers:
  - the accumulated low-order sum bits;
  - the not-yet-consumed high operand bits, B already inverted when iSub=1;
  - the running carry;
  - the carry into the MSB (last stage only, for overflow).
- Latency: an operation accepted at edge t appears on oValid/oSum at edge t+NUM_STAGES, provided there are no stalls.
- Throughput: one operation per cycle when iReady=1.
- Handshake and advance rules:
  - transfer in on iValid&&oReady; transfer out on oValid&&iReady;
  - stage s advances when it is empty or stage s+1 advances;
  - the last stage advances when it is empty or iReady=1;
  - oReady = advance of stage 0 (combinational, but not dependent on iValid);
  - bubbles collapse: an empty stage accepts even if downstream stalls.
- Stall: while oValid=1 and iReady=0, oSum/oCarry/oOverflow/oValid hold stable. Upstream stages fill and then deassert oReady.
- Operand capture: inputs are sampled only on accepted transfers; iA/iB/iCarry/iSub are don't-care otherwise.
- Simultaneous in/out at full occupancy with iReady=1: the pipeline shifts, and both transfers occur in the same cycle.
- Wrap-around: the sum is modulo 2^ADDER_WIDTH; the overflowed bit is reported only via oCarry.
- NUM_STAGES=1 degenerates to a single registered carry-skip adder with the same handshake.

Decomposition:
- Shared package pcsa_pkg holds:
  - localparams NUM_BLOCKS and BLOCKS_PER_STAGE;
  - elaboration-time checks (width divisibility), failing with $error;
  - a stage-record typedef (valid, sum, remaining A/B, carry, msb_carry_in).
- Sub-module carry_skip_block: BLOCK_WIDTH ripple plus propagate AND plus skip mux (ports a, b, cin, sum, cout, msb_cin).
- Top generates NUM_STAGES × BLOCKS_PER_STAGE instances and owns the stage registers and handshake.

Test Plan:
- Reset with defaults: hold iRst 3 cycles with iValid=1 -> oReady=0, oValid=0, oSum=0; first cycle after release oReady=1.
- Add with full skip path: A=0xFFFFFFFF, B=0x00000000, iCarry=1, iSub=0, iReady=1 -> 2 cycles later oValid=1, oSum=0, oCarry=1, oOverflow=0.
- Subtract with signed overflow: A=0x80000000, B=0x00000001, iSub=1 -> oSum=0x7FFFFFFF, oCarry=1, oOverflow=1.
- Back-to-back throughput: 8 consecutive random ops with iReady=1 -> 8 consecutive oValid cycles in order, each oSum matching the reference model.
- Backpressure: stream 4 ops, iReady=0 for 5 cycles -> oReady falls after the pipeline fills (2 ops held); outputs are stable; on iReady=1 the results drain in order with none lost or duplicated.
- Reset mid-flight plus non-default config: ADDER_WIDTH=16, BLOCK_WIDTH=2, NUM_STAGES=4; accept 3 ops, pulse iRst -> no oValid afterwards. Then 0x7FFF+0x0001 -> oSum=0x8000, oOverflow=1, latency 4.
